// File: rtl/fifo_rd_stream_pkg.sv
// Shared types, constants and helpers for the FIFO read-side drain stage.
package fifo_rd_stream_pkg;

  // Prefetch buffer geometry: three entries cover the two-cycle issue-to-visible latency plus one.
  localparam int unsigned BUF_ENTRIES = 3;
  localparam int unsigned PTR_W       = 2;
  localparam int unsigned CNT_W       = 2;

  // Default-width view of one stream beat, for consumers at the standard data width.
  localparam int unsigned BEAT_DW = 8;

  typedef struct packed {
    logic [BEAT_DW-1:0] data;
    logic               last;
  } stream_beat_t;

  // Advance a buffer pointer, wrapping after the last entry.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(BUF_ENTRIES - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_prefetch_buf.sv
// Three-entry circular prefetch buffer with occupancy count and flop-based read port.
module fifo_rd_prefetch_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [CNT_W-1:0]      count_o,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_ENTRIES];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Next pointers and count; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ptr_next(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_next(rd_ptr_q);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State and storage registers; reset discards all buffered content.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < BUF_ENTRIES; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains an async FIFO's registered read port into a valid/ready stream with packet framing.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PKT_LEN    = 4
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [1:0]            buf_count
);

  localparam int unsigned BEAT_W = $clog2(PKT_LEN) + 1;
  localparam int unsigned OCC_W  = CNT_W + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  logic                  inflight_q, inflight_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]      count;
  logic [OCC_W-1:0]      occupancy;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  pop;

  // Entries held plus the one still in flight; issuing only below capacity means captures never overflow.
  assign occupancy = {1'b0, count} + OCC_W'(inflight_q);

  // Issue from registered state and the empty flag only; held low while reset is asserted.
  assign fifo_r_en = rrst_n & ~fifo_empty & (occupancy < OCC_W'(BUF_ENTRIES));

  assign m_valid   = (count != '0);
  assign pop       = m_valid & m_ready;
  assign m_data    = rd_data;
  assign m_last    = m_valid & (beat_cnt_q == LAST_BEAT);
  assign buf_count = count;

  // Next inflight flag and packet beat position.
  always_comb begin
    inflight_d = fifo_r_en;
    beat_cnt_d = beat_cnt_q;
    if (pop) beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + BEAT_W'(1);
  end

  // Issue tracking and framing registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  fifo_rd_prefetch_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk         (rclk),
    .rst_n       (rrst_n),
    .push_i      (inflight_q),
    .push_data_i (fifo_data),
    .pop_i       (pop),
    .count_o     (count),
    .rd_data_o   (rd_data)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: FIFO model, scoreboard and framing checks.
module tb_fifo_rd_stream;

  localparam int unsigned DW  = 8;
  localparam int          PKT = 4;

  logic          rclk       = 1'b0;
  logic          rrst_n     = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data  = '0;
  logic          m_ready    = 1'b0;

  logic          fifo_r_en, m_valid, m_last;
  logic [DW-1:0] m_data;
  logic [1:0]    buf_count;

  logic          p1_r_en, p1_valid, p1_last;
  logic [DW-1:0] p1_data;
  logic [1:0]    p1_count;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_reads = 0;
  int            n_acc   = 0;
  int            exp_beat = 0;
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q  [$];
  logic [DW-1:0] last_seen = '0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  bit            prev_stall = 1'b0;
  bit            force_empty = 1'b0;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(PKT)) u_dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .buf_count  (buf_count)
  );

  // Single-beat-packet variant fed identically; its m_last must accompany every beat.
  fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(1)) u_dut_p1 (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (p1_r_en),
    .m_valid    (p1_valid),
    .m_ready    (m_ready),
    .m_data     (p1_data),
    .m_last     (p1_last),
    .buf_count  (p1_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic upd_empty();
    fifo_empty = (fifo_q.size() == 0) || force_empty;
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
    upd_empty();
  endtask

  // Scoreboard: ordering, framing and hold-while-stalled checks, sampled mid-cycle.
  task automatic monitor();
    logic [DW-1:0] e;
    if (rrst_n && prev_stall && m_valid) begin
      check("hold_data", m_data, prev_data);
      check("hold_last", m_last, prev_last);
    end
    if (rrst_n && m_valid && m_ready) begin
      check("p1_last", p1_last, 1'b1);
      if (exp_q.size() == 0) begin
        check("extra_beat", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("data", m_data, e);
        check("p1_data", p1_data, e);
        check("last", m_last, exp_beat == PKT - 1);
        if (m_last) last_seen = m_data;
        exp_beat = (exp_beat + 1) % PKT;
        n_acc++;
      end
    end
    prev_stall = rrst_n && m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
  endtask

  // One clock: sample at negedge, model the FIFO's registered read at posedge, then re-drive.
  task automatic cyc();
    @(negedge rclk);
    monitor();
    @(posedge rclk);
    if (fifo_r_en && !fifo_empty) begin
      fifo_data <= fifo_q.pop_front();
      n_reads++;
    end
    #1;
    upd_empty();
    #1;
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    exp_beat   = 0;
    prev_stall = 1'b0;
    upd_empty();
    repeat (2) cyc();
    rrst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
    $fatal;
  end

  initial begin
    // Reset with a non-empty FIFO holding 0xA5.
    m_ready = 1'b1;
    push(8'hA5);
    repeat (3) cyc();
    check("rst_ren", fifo_r_en, 1'b0);
    check("rst_valid", m_valid, 1'b0);
    check("rst_count", buf_count, 2'd0);
    check("rst_data", m_data, 8'h00);
    check("rst_last", m_last, 1'b0);
    check("rst_p1_ren", p1_r_en, 1'b0);
    rrst_n  = 1'b1;
    n_reads = 0;
    #1;
    check("rel_ren", fifo_r_en, 1'b1);

    // Single beat: one read, visible two cycles after issue.
    cyc();
    check("one_ren_off", fifo_r_en, 1'b0);
    check("one_valid_n1", m_valid, 1'b0);
    cyc();
    check("one_valid_n2", m_valid, 1'b1);
    check("one_data", m_data, 8'hA5);
    check("one_last4", m_last, 1'b0);
    check("one_last1", p1_last, 1'b1);
    repeat (2) cyc();
    check("one_reads", n_reads, 1);
    check("one_empty", m_valid, 1'b0);

    // Streaming 0x00..0x0F at full rate.
    do_reset();
    n_acc = 0; n_reads = 0;
    for (int i = 0; i < 16; i++) push(DW'(i));
    repeat (3) cyc();
    check("stream_fill", n_acc, 1);
    repeat (14) cyc();
    check("stream_rate", n_acc, 15);
    cyc();
    check("stream_done", n_acc, 16);
    check("stream_reads", n_reads, 16);
    check("stream_count", buf_count, 2'd0);

    // Backpressure: buffer fills to 3 and holds its head.
    n_reads = 0; n_acc = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(DW'(i));
    repeat (10) cyc();
    check("bp_reads", n_reads, 3);
    check("bp_count", buf_count, 2'd3);
    check("bp_valid", m_valid, 1'b1);
    check("bp_data", m_data, 8'h00);
    m_ready = 1'b1;
    repeat (12) cyc();
    check("bp_acc", n_acc, 6);
    check("bp_drained", exp_q.size(), 0);
    check("bp_count_end", buf_count, 2'd0);

    // Bursty ready with randomly gated FIFO availability.
    for (int i = 0; i < 30; i++) push(DW'(8'h40 + i));
    for (int i = 0; i < 120; i++) begin
      m_ready     = ~m_ready;
      force_empty = ($urandom_range(0, 1) == 1);
      upd_empty();
      cyc();
    end
    m_ready     = 1'b1;
    force_empty = 1'b0;
    upd_empty();
    repeat (40) cyc();
    check("burst_drained", exp_q.size(), 0);
    check("burst_count", buf_count, 2'd0);
    check("burst_p1_count", p1_count, 2'd0);

    // Reset after two beats of a packet, then framing restarts.
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 16; i++) push(DW'(8'h20 + i));
    for (int i = 0; i < 20 && n_acc < 2; i++) cyc();
    check("mid_wait", n_acc, 2);
    rrst_n = 1'b0;
    #1;
    check("mid_valid", m_valid, 1'b0);
    check("mid_count", buf_count, 2'd0);
    check("mid_ren", fifo_r_en, 1'b0);
    check("mid_data", m_data, 8'h00);
    check("mid_last", m_last, 1'b0);
    do_reset();
    n_acc = 0;
    last_seen = '0;
    for (int i = 0; i < 8; i++) push(DW'(8'h30 + i));
    repeat (6) cyc();
    check("post_acc", n_acc, 4);
    check("post_last1", last_seen, 8'h33);
    repeat (6) cyc();
    check("post_acc2", n_acc, 8);
    check("post_last2", last_seen, 8'h37);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
